lut_neuron_prog: RTL and testbench



---
 rtl/lut_neuron_prog_if.sv | 30 +++
 rtl/lut_neuron_prog.sv | 143 ++++++++++++++
 tb/tb_lut_neuron_prog.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_neuron_prog_if.sv
// Handshake bundle for lut_neuron_prog: streaming table-config port plus
// the input/output valid/ready activation channels.
interface lut_neuron_prog_if #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_W = 2
);
    logic             cfg_start;
    logic             cfg_wvalid;
    logic [OUT_W-1:0] cfg_wdata;
    logic             cfg_done;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_perr;

    modport master (
        output cfg_start, cfg_wvalid, cfg_wdata, in_valid, in_data, out_ready,
        input  cfg_done, in_ready, out_valid, out_data, out_perr
    );

    modport slave (
        input  cfg_start, cfg_wvalid, cfg_wdata, in_valid, in_data, out_ready,
        output cfg_done, in_ready, out_valid, out_data, out_perr
    );
endinterface

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: 2^IN_W x OUT_W table loaded over a stream,
// 1-cycle registered lookup behind valid/ready. Optional macro LUT_PARITY_EN.
module lut_neuron_prog #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    lut_neuron_prog_if.slave bus
);

    localparam int unsigned DEPTH = 1 << IN_W;
`ifdef LUT_PARITY_EN
    localparam int unsigned ENT_W = OUT_W + 1;
`else
    localparam int unsigned ENT_W = OUT_W;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StRun} state_e;

    state_e           state_q;
    logic [IN_W-1:0]  addr_q;
    logic [ENT_W-1:0] table_q [DEPTH];
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             cfg_done_q;

    logic             in_ready;
    logic             accept;
    logic             out_hs;
    logic             valid_next;
    logic             wr_en;
    logic             last_beat;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;
    logic             rd_perr;

    always_comb begin
        in_ready   = (state_q == StRun) && (!out_valid_q || bus.out_ready);
        accept     = bus.in_valid && in_ready;
        out_hs     = out_valid_q && bus.out_ready;
        valid_next = accept || (out_valid_q && !bus.out_ready);
        // A restart pulse takes priority over a coincident write beat.
        wr_en      = (state_q == StLoad) && bus.cfg_wvalid && !bus.cfg_start;
        last_beat  = wr_en && (addr_q == {IN_W{1'b1}});
        rd_entry   = table_q[bus.in_data];
`ifdef LUT_PARITY_EN
        wr_entry   = {^bus.cfg_wdata, bus.cfg_wdata};
        rd_perr    = ^rd_entry;
`else
        wr_entry   = bus.cfg_wdata;
        rd_perr    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[addr_q] <= wr_entry;
        end
    end

`ifdef LUT_PARITY_EN
    logic out_perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_perr_q <= 1'b0;
        end else if (accept) begin
            out_perr_q <= rd_perr;
        end
    end

    assign bus.out_perr = out_perr_q;
`else
    logic unused_perr;
    assign unused_perr  = rd_perr;
    assign bus.out_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            cfg_done_q <= 1'b0;

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rd_entry[OUT_W-1:0];
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.cfg_start) begin
                        state_q <= StLoad;
                        addr_q  <= '0;
                    end
                end
                StLoad: begin
                    if (bus.cfg_start) begin
                        addr_q <= '0;
                    end else if (wr_en) begin
                        addr_q <= addr_q + 1'b1;
                        if (last_beat) begin
                            state_q    <= StRun;
                            cfg_done_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (!out_valid_q || out_hs) begin
                        state_q <= StLoad;
                        addr_q  <= '0;
                    end
                end
                StRun: begin
                    // Decide on the post-edge valid so a result leaving this cycle
                    // or one accepted this cycle is accounted for.
                    if (bus.cfg_start) begin
                        state_q <= valid_next ? StDrain : StLoad;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Self-checking bench for lut_neuron_prog: table-driven lookups, hand-written
// backpressure/reload/reset sequences and random traffic against a scoreboard.
module tb_lut_neuron_prog;

    localparam int unsigned IN_W  = 7;
    localparam int unsigned OUT_W = 2;
    localparam int unsigned DEPTH = 1 << IN_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_neuron_prog_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    lut_neuron_prog #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [IN_W-1:0]  addr;
        logic [OUT_W-1:0] exp;
    } vec_t;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned ref_tbl [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: table[i]=i[1:0], 1: ~i[1:0], 2: random
    task automatic load_table(input int mode);
        int early = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            case (mode)
                0:       ref_tbl[i] = i % 4;
                1:       ref_tbl[i] = 3 - (i % 4);
                default: ref_tbl[i] = $urandom_range(0, 3);
            endcase
        end
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk("load_in_ready", bus.in_ready, 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.cfg_wvalid = 1'b0;
                tick();
                if (bus.cfg_done) early++;
            end
            bus.cfg_wvalid = 1'b1;
            bus.cfg_wdata  = OUT_W'(ref_tbl[i]);
            tick();
            if (i < int'(DEPTH) - 1 && bus.cfg_done) early++;
        end
        bus.cfg_wvalid = 1'b0;
        chk("cfg_done_pulse", bus.cfg_done, 1);
        chk("run_in_ready", bus.in_ready, 1);
        chk("cfg_done_early", early, 0);
        tick();
        chk("cfg_done_single", bus.cfg_done, 0);
    endtask

    task automatic lookup(input logic [IN_W-1:0] addr, input logic [OUT_W-1:0] exp);
        bus.in_valid  = 1'b1;
        bus.in_data   = addr;
        bus.out_ready = 1'b1;
        #1;
        chk("lookup_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("lookup_valid", bus.out_valid, 1);
        chk($sformatf("lookup_data_%0h", addr), bus.out_data, exp);
        chk("lookup_perr", bus.out_perr, 0);
        tick();
        chk("lookup_clear", bus.out_valid, 0);
    endtask

    // Random traffic against a 1-deep result queue built from ref_tbl.
    task automatic run_random(input int cycles);
        int unsigned q[$];
        int bad = 0;
        int outs = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_data   = IN_W'($urandom_range(0, DEPTH - 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid !== (q.size() != 0)) bad++;
            if (bus.in_ready !== ((q.size() == 0) || bus.out_ready)) bad++;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0 || bus.out_data !== OUT_W'(q[0])) bad++;
                if (q.size() != 0) void'(q.pop_front());
                outs++;
            end
            if (bus.in_valid && bus.in_ready) q.push_back(ref_tbl[bus.in_data]);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("random_errors", bad, 0);
        chk("random_activity", (outs > cycles / 8), 1);
        chk("random_drained", bus.out_valid, 0);
    endtask

    vec_t vecs [8];

    initial begin
        int bad;
        int good;
        int bubbles;
`ifdef LUT_PARITY_EN
        logic [OUT_W:0] flip_ent;
`endif
        vecs[0] = '{7'h05, 2'b01};
        vecs[1] = '{7'h7E, 2'b10};
        vecs[2] = '{7'h00, 2'b00};
        vecs[3] = '{7'h7F, 2'b11};
        vecs[4] = '{7'h03, 2'b11};
        vecs[5] = '{7'h40, 2'b00};
        vecs[6] = '{7'h2A, 2'b10};
        vecs[7] = '{7'h11, 2'b01};

        bus.cfg_start  = 1'b0;
        bus.cfg_wvalid = 1'b0;
        bus.cfg_wdata  = '0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 7'h05;
        bus.out_ready  = 1'b1;

        // Reset held with input offered, then released while unprogrammed.
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.out_valid || bus.in_ready || bus.cfg_done || bus.out_data != 0) bad++;
        end
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_cfg_done", bus.cfg_done, 0);
        chk("rst_out_perr", bus.out_perr, 0);
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (bus.out_valid || bus.in_ready || bus.cfg_done) bad++;
        end
        chk("idle_no_output", bad, 0);
        bus.in_valid = 1'b0;

        load_table(0);
        for (int i = 0; i < 8; i++) lookup(vecs[i].addr, vecs[i].exp);

        // Back-to-back stream 0..127.
        good = 0;
        bubbles = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = IN_W'(i);
            #1;
            if (!bus.in_ready) bubbles++;
            tick();
            if (bus.out_valid && bus.out_data == OUT_W'(i % 4)) good++;
        end
        bus.in_valid = 1'b0;
        chk("stream_bubbles", bubbles, 0);
        chk("stream_results", good, DEPTH);
        tick();

        // Backpressure holds output and blocks input.
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h05;
        tick();
        bus.out_ready = 1'b0;
        bus.in_data   = 7'h7E;
        #1;
        chk("bp_in_ready", bus.in_ready, 0);
        bad = 0;
        repeat (3) begin
            tick();
            if (!bus.out_valid || bus.out_data !== 2'b01) bad++;
        end
        chk("bp_hold", bad, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_7e_valid", bus.out_valid, 1);
        chk("bp_7e_data", bus.out_data, 2'b10);
        tick();
        chk("bp_drained", bus.out_valid, 0);

        // Reload with a result stalled: DRAIN, stray beats ignored, then LOAD.
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h05;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk("drain_in_ready", bus.in_ready, 0);
        chk("drain_out_valid", bus.out_valid, 1);
        bus.cfg_wvalid = 1'b1;
        bus.cfg_wdata  = 2'b11;
        tick();
        tick();
        bus.cfg_wvalid = 1'b0;
        chk("drain_hold_data", bus.out_data, 2'b01);
        bus.out_ready = 1'b1;
        tick();
        chk("drain_released", bus.out_valid, 0);
        chk("load_after_drain_ready", bus.in_ready, 0);
        // The start pulse inside load_table restarts the counter in LOAD.
        load_table(1);
        lookup(7'h05, 2'b10);
        lookup(7'h7E, 2'b01);

        load_table(2);
        run_random(400);

        // Reset in the middle of a load.
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start  = 1'b0;
        bus.cfg_wvalid = 1'b1;
        repeat (40) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midload_rst_valid", bus.out_valid, 0);
        chk("midload_rst_ready", bus.in_ready, 0);
        chk("midload_rst_done", bus.cfg_done, 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (bus.cfg_done || bus.in_ready) bad++;
        end
        bus.cfg_wvalid = 1'b0;
        chk("idle_ignores_wvalid", bad, 0);
        load_table(0);
        lookup(7'h05, 2'b01);
        lookup(7'h7E, 2'b10);

`ifdef LUT_PARITY_EN
        flip_ent = dut.table_q[5] ^ 3'b001;
        force dut.table_q[5] = flip_ent;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h05;
        tick();
        chk("perr_flipped", bus.out_perr, 1);
        bus.in_data = 7'h06;
        tick();
        bus.in_valid = 1'b0;
        chk("perr_clean", bus.out_perr, 0);
        release dut.table_q[5];
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
